// File: rtl/hazard_ctrl.sv
// hazard_ctrl: pipeline hazard controller for the five-stage CPU.
// Resolves load-use and flag-dependency stalls, taken-branch flushes and
// front-end freezing during multi-cycle multiplies. It also keeps
// saturating stall/flush performance counters.
module hazard_ctrl #(
    parameter int MUL_LAT = 4,
    parameter int CNT_W   = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [4:0]       id_Rn,
    input  logic [4:0]       id_Rm,
    input  logic             id_useRn,
    input  logic             id_useRm,
    input  logic             id_isCondBr,
    input  logic             ex_MemRead,
    input  logic [4:0]       ex_Rd,
    input  logic             ex_FlagEn,
    input  logic             ex_mulStart,
    input  logic             mem_brTaken,
    output logic             pc_en,
    output logic             ifid_en,
    output logic             idex_en,
    output logic             ifid_flush,
    output logic             idex_flush,
    output logic             exmem_flush,
    output logic [CNT_W-1:0] stall_cnt,
    output logic [CNT_W-1:0] flush_cnt
);

    typedef enum logic [1:0] {
        RUN,
        MUL,
        LAST
    } state_t;

    // A one-cycle multiply never stalls; longer ones stall MUL_LAT-1 cycles,
    // the first of them in RUN, so the countdown starts at MUL_LAT-2.
    localparam bit         MUL_STALLS = (MUL_LAT >= 2);
    localparam logic [3:0] REM_INIT   = MUL_STALLS ? 4'(MUL_LAT - 2) : 4'd0;

    state_t     state, state_nx;
    logic [3:0] rem, rem_nx;

    logic rn_hit, rm_hit, load_use, flag_haz, bubble;

    assign rn_hit   = id_useRn && (id_Rn == ex_Rd);
    assign rm_hit   = id_useRm && (id_Rm == ex_Rd);
    // XZR reads as zero and never carries a loaded value.
    assign load_use = ex_MemRead && (ex_Rd != 5'd31) && (rn_hit || rm_hit);
    assign flag_haz = id_isCondBr && ex_FlagEn;
    assign bubble   = load_use || flag_haz;

    // State and multiply countdown register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= RUN;
            rem   <= '0;
        end else begin
            state <= state_nx;
            rem   <= rem_nx;
        end
    end

    // Next-state and Mealy output decode, highest-priority hazard first.
    always_comb begin
        pc_en       = 1'b1;
        ifid_en     = 1'b1;
        idex_en     = 1'b1;
        ifid_flush  = 1'b0;
        idex_flush  = 1'b0;
        exmem_flush = 1'b0;
        state_nx    = state;
        rem_nx      = rem;

        if (rst) begin
            pc_en    = 1'b0;
            ifid_en  = 1'b0;
            idex_en  = 1'b0;
            state_nx = RUN;
            rem_nx   = '0;
        end else if (mem_brTaken) begin
            // Everything younger than the branch, including a multiply, dies.
            ifid_flush  = 1'b1;
            idex_flush  = 1'b1;
            exmem_flush = 1'b1;
            state_nx    = RUN;
            rem_nx      = '0;
        end else begin
            case (state)
                RUN: begin
                    if (ex_mulStart && MUL_STALLS) begin
                        pc_en       = 1'b0;
                        ifid_en     = 1'b0;
                        idex_en     = 1'b0;
                        exmem_flush = 1'b1;
                        rem_nx      = REM_INIT;
                        state_nx    = (REM_INIT != 4'd0) ? MUL : LAST;
                    end else if (bubble) begin
                        pc_en      = 1'b0;
                        ifid_en    = 1'b0;
                        idex_flush = 1'b1;
                    end
                end
                MUL: begin
                    pc_en       = 1'b0;
                    ifid_en     = 1'b0;
                    idex_en     = 1'b0;
                    exmem_flush = 1'b1;
                    if (rem <= 4'd1) begin
                        rem_nx   = '0;
                        state_nx = LAST;
                    end else begin
                        rem_nx = rem - 4'd1;
                    end
                end
                LAST: begin
                    // The multiply is still in ID/EX, so ex_mulStart is ignored.
                    if (bubble) begin
                        pc_en      = 1'b0;
                        ifid_en    = 1'b0;
                        idex_flush = 1'b1;
                    end
                    state_nx = RUN;
                end
                default: begin
                    state_nx = RUN;
                    rem_nx   = '0;
                end
            endcase
        end
    end

    // Saturating performance counters.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            stall_cnt <= '0;
            flush_cnt <= '0;
        end else begin
            if (!pc_en && (stall_cnt != '1))
                stall_cnt <= stall_cnt + CNT_W'(1);
            if (mem_brTaken && (flush_cnt != '1))
                flush_cnt <= flush_cnt + CNT_W'(1);
        end
    end

endmodule

// File: tb/tb_hazard_ctrl.sv
// tb_hazard_ctrl: directed-vector bench for hazard_ctrl (MUL_LAT=4, CNT_W=4).
module tb_hazard_ctrl;

    logic       clk = 1'b0;
    logic       rst;
    logic [4:0] id_Rn, id_Rm, ex_Rd;
    logic       id_useRn, id_useRm, id_isCondBr;
    logic       ex_MemRead, ex_FlagEn, ex_mulStart, mem_brTaken;
    logic       pc_en, ifid_en, idex_en, ifid_flush, idex_flush, exmem_flush;
    logic [3:0] stall_cnt, flush_cnt;
    logic [5:0] ctl;

    int unsigned total = 0;
    int unsigned bad   = 0;

    // ctl = {pc_en, ifid_en, idex_en, ifid_flush, idex_flush, exmem_flush}
    localparam logic [5:0] C_IDLE   = 6'b111_000;
    localparam logic [5:0] C_BUBBLE = 6'b001_010;
    localparam logic [5:0] C_MUL    = 6'b000_001;
    localparam logic [5:0] C_FLUSH  = 6'b111_111;
    localparam logic [5:0] C_RESET  = 6'b000_000;

    hazard_ctrl #(
        .MUL_LAT(4),
        .CNT_W  (4)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .id_Rn      (id_Rn),
        .id_Rm      (id_Rm),
        .id_useRn   (id_useRn),
        .id_useRm   (id_useRm),
        .id_isCondBr(id_isCondBr),
        .ex_MemRead (ex_MemRead),
        .ex_Rd      (ex_Rd),
        .ex_FlagEn  (ex_FlagEn),
        .ex_mulStart(ex_mulStart),
        .mem_brTaken(mem_brTaken),
        .pc_en      (pc_en),
        .ifid_en    (ifid_en),
        .idex_en    (idex_en),
        .ifid_flush (ifid_flush),
        .idex_flush (idex_flush),
        .exmem_flush(exmem_flush),
        .stall_cnt  (stall_cnt),
        .flush_cnt  (flush_cnt)
    );

    assign ctl = {pc_en, ifid_en, idex_en, ifid_flush, idex_flush, exmem_flush};

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Apply one cycle's inputs, then let the combinational outputs settle.
    task automatic apply(input logic mr, input logic [4:0] rd,
                         input logic [4:0] rn, input logic urn,
                         input logic [4:0] rm, input logic urm,
                         input logic cb, input logic fe,
                         input logic ms, input logic bt);
        ex_MemRead  = mr;
        ex_Rd       = rd;
        id_Rn       = rn;
        id_useRn    = urn;
        id_Rm       = rm;
        id_useRm    = urm;
        id_isCondBr = cb;
        ex_FlagEn   = fe;
        ex_mulStart = ms;
        mem_brTaken = bt;
        #1;
    endtask

    task automatic idle_in();
        apply(0, 5'd0, 5'd0, 0, 5'd0, 0, 0, 0, 0, 0);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        rst = 1'b1;
        // Reset forces everything off even with hazards present.
        apply(1, 5'd3, 5'd3, 1, 5'd0, 0, 1, 1, 1, 1);
        #10;
        chk("reset_ctl", 32'(ctl), 32'(C_RESET));
        chk("reset_stall_cnt", 32'(stall_cnt), 0);
        chk("reset_flush_cnt", 32'(flush_cnt), 0);
        idle_in();
        @(negedge clk);
        rst = 1'b0;
        tick();
        idle_in();
        chk("idle_ctl", 32'(ctl), 32'(C_IDLE));

        // Load-use on Rn: LDUR X3 then ADD X4,X3,X5.
        apply(1, 5'd3, 5'd3, 1, 5'd5, 1, 0, 0, 0, 0);
        chk("lu_rn_ctl", 32'(ctl), 32'(C_BUBBLE));
        chk("lu_rn_cnt_before", 32'(stall_cnt), 0);
        tick();
        idle_in();
        chk("lu_rn_release", 32'(ctl), 32'(C_IDLE));
        chk("lu_rn_cnt_after", 32'(stall_cnt), 1);

        // Load-use on Rm; then the same registers with useRm clear.
        apply(1, 5'd7, 5'd1, 1, 5'd7, 1, 0, 0, 0, 0);
        chk("lu_rm_ctl", 32'(ctl), 32'(C_BUBBLE));
        tick();
        apply(1, 5'd7, 5'd1, 1, 5'd7, 0, 0, 0, 0, 0);
        chk("lu_rm_unused", 32'(ctl), 32'(C_IDLE));
        tick();
        // XZR never hazards.
        apply(1, 5'd31, 5'd31, 1, 5'd31, 1, 0, 0, 0, 0);
        chk("xzr_ctl", 32'(ctl), 32'(C_IDLE));
        tick();
        chk("xzr_cnt", 32'(stall_cnt), 2);

        // Flag hazard, then B.cond without a flag writer.
        apply(0, 5'd0, 5'd0, 0, 5'd0, 0, 1, 1, 0, 0);
        chk("flag_ctl", 32'(ctl), 32'(C_BUBBLE));
        tick();
        apply(0, 5'd0, 5'd0, 0, 5'd0, 0, 1, 0, 0, 0);
        chk("flag_nowriter", 32'(ctl), 32'(C_IDLE));
        tick();
        chk("flag_cnt", 32'(stall_cnt), 3);
        // Flag hazard together with a taken branch: flush only.
        apply(0, 5'd0, 5'd0, 0, 5'd0, 0, 1, 1, 0, 1);
        chk("flag_br_ctl", 32'(ctl), 32'(C_FLUSH));
        tick();
        idle_in();
        chk("flag_br_stall_cnt", 32'(stall_cnt), 3);
        chk("flag_br_flush_cnt", 32'(flush_cnt), 1);

        // Multiply held for four cycles: three stall cycles, none in LAST.
        for (int i = 0; i < 3; i++) begin
            apply(0, 5'd0, 5'd0, 0, 5'd0, 0, 0, 0, 1, 0);
            chk($sformatf("mul_stall%0d", i), 32'(ctl), 32'(C_MUL));
            tick();
        end
        apply(0, 5'd0, 5'd0, 0, 5'd0, 0, 0, 0, 1, 0);
        chk("mul_last_no_retrigger", 32'(ctl), 32'(C_IDLE));
        tick();
        idle_in();
        chk("mul_run_after", 32'(ctl), 32'(C_IDLE));
        chk("mul_stall_cnt", 32'(stall_cnt), 6);

        // Load-use hidden during MUL, re-evaluated in LAST.
        apply(0, 5'd0, 5'd0, 0, 5'd0, 0, 0, 0, 1, 0);
        chk("mul_lu_start", 32'(ctl), 32'(C_MUL));
        tick();
        apply(1, 5'd9, 5'd9, 1, 5'd0, 0, 0, 0, 1, 0);
        chk("mul_lu_hidden1", 32'(ctl), 32'(C_MUL));
        tick();
        chk("mul_lu_hidden2", 32'(ctl), 32'(C_MUL));
        tick();
        chk("mul_lu_last_bubble", 32'(ctl), 32'(C_BUBBLE));
        tick();
        idle_in();
        chk("mul_lu_cnt", 32'(stall_cnt), 10);

        // Branch during the second multiply stall cycle.
        apply(0, 5'd0, 5'd0, 0, 5'd0, 0, 0, 0, 1, 0);
        chk("mul_br_first", 32'(ctl), 32'(C_MUL));
        tick();
        apply(0, 5'd0, 5'd0, 0, 5'd0, 0, 0, 0, 1, 1);
        chk("mul_br_flush", 32'(ctl), 32'(C_FLUSH));
        tick();
        idle_in();
        chk("mul_br_back_run", 32'(ctl), 32'(C_IDLE));
        chk("mul_br_stall_cnt", 32'(stall_cnt), 11);
        chk("mul_br_flush_cnt", 32'(flush_cnt), 2);

        // Branch and multiply start together in RUN: flush wins, stay RUN.
        apply(0, 5'd0, 5'd0, 0, 5'd0, 0, 0, 0, 1, 1);
        chk("br_mul_same_ctl", 32'(ctl), 32'(C_FLUSH));
        tick();
        idle_in();
        chk("br_mul_same_next", 32'(ctl), 32'(C_IDLE));
        chk("br_mul_same_fcnt", 32'(flush_cnt), 3);

        // Stall counter saturation with a held load-use.
        apply(1, 5'd2, 5'd2, 1, 5'd0, 0, 0, 0, 0, 0);
        for (int i = 0; i < 20; i++) tick();
        chk("sat_ctl", 32'(ctl), 32'(C_BUBBLE));
        chk("sat_stall_cnt", 32'(stall_cnt), 15);

        // Flush counter saturation.
        apply(0, 5'd0, 5'd0, 0, 5'd0, 0, 0, 0, 0, 1);
        for (int i = 0; i < 16; i++) tick();
        chk("sat_flush_cnt", 32'(flush_cnt), 15);

        // Reset mid-multiply aborts it immediately.
        apply(0, 5'd0, 5'd0, 0, 5'd0, 0, 0, 0, 1, 0);
        tick();
        chk("rst_mid_in_mul", 32'(ctl), 32'(C_MUL));
        rst = 1'b1;
        #1;
        chk("rst_mid_ctl", 32'(ctl), 32'(C_RESET));
        chk("rst_mid_stall_cnt", 32'(stall_cnt), 0);
        chk("rst_mid_flush_cnt", 32'(flush_cnt), 0);
        tick();
        idle_in();
        rst = 1'b0;
        #1;
        chk("rst_release_run", 32'(ctl), 32'(C_IDLE));
        tick();
        chk("rst_release_next", 32'(ctl), 32'(C_IDLE));
        chk("rst_release_cnt", 32'(stall_cnt), 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL timeout: got running expected finished");
        $fatal(1);
    end

endmodule
